// File: rtl/vend_pkg.sv
// Shared vending definitions: one-hot coin codes, their unit values and the
// payout state encoding. The vending FSM reuses the coin codes.
package vend_pkg;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_5    = 3'b100;

    localparam int unsigned COIN_1_VAL = 1;
    localparam int unsigned COIN_2_VAL = 2;
    localparam int unsigned COIN_5_VAL = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int unsigned coin_value(input logic [2:0] code);
        case (code)
            COIN_1:  return COIN_1_VAL;
            COIN_2:  return COIN_2_VAL;
            COIN_5:  return COIN_5_VAL;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_coin_select.sv
// Greedy coin picker: largest non-empty denomination whose value fits in remain.
module vend_coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic [AMT_W-1:0] remain,
    input  logic [2:0]       empty,
    output logic [2:0]       coin_code,
    output logic             found
);

    localparam logic [AMT_W-1:0] V1 = AMT_W'(COIN_1_VAL);
    localparam logic [AMT_W-1:0] V2 = AMT_W'(COIN_2_VAL);
    localparam logic [AMT_W-1:0] V5 = AMT_W'(COIN_5_VAL);

    always_comb begin
        coin_code = COIN_NONE;
        found     = 1'b0;
        if (!empty[2] && remain >= V5) begin
            coin_code = COIN_5;
            found     = 1'b1;
        end else if (!empty[1] && remain >= V2) begin
            coin_code = COIN_2;
            found     = 1'b1;
        end else if (!empty[0] && remain >= V1) begin
            coin_code = COIN_1;
            found     = 1'b1;
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout controller: pays out an amount one coin at a time to the hopper.
// Optional macro VEND_COIN_TALLY_EN adds saturating per-denomination acked-coin counters.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [2:0]       empty,
    output logic             coin_valid,
    output logic [2:0]       coin_code,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             fault,
    output logic [AMT_W-1:0] remain
`ifdef VEND_COIN_TALLY_EN
    ,
    output logic [7:0]       tally1,
    output logic [7:0]       tally2,
    output logic [7:0]       tally5
`endif
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remain_q, remain_d;
    logic             coin_valid_q, coin_valid_d;
    logic [2:0]       coin_code_q, coin_code_d;
    logic             short_q, short_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       sel_code;
    logic             sel_found;

    vend_coin_select #(.AMT_W(AMT_W)) u_select (
        .remain    (remain_q),
        .empty     (empty),
        .coin_code (sel_code),
        .found     (sel_found)
    );

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        coin_valid_d = coin_valid_q;
        coin_code_d  = coin_code_q;
        short_d      = short_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remain_d = amount;
                    short_d  = 1'b0;
                    fault_d  = 1'b0;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                cnt_d = '0;
                if (remain_q == '0) begin
                    state_d = DONE;
                end else if (!sel_found) begin
                    short_d = 1'b1;
                    state_d = DONE;
                end else begin
                    coin_code_d  = sel_code;
                    coin_valid_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // ack takes priority over a timeout landing on the same edge
                if (coin_ack) begin
                    remain_d     = remain_q - AMT_W'(coin_value(coin_code_q));
                    coin_valid_d = 1'b0;
                    coin_code_d  = COIN_NONE;
                    state_d      = SELECT;
                end else if (cnt_q == CNT_MAX) begin
                    fault_d      = 1'b1;
                    coin_valid_d = 1'b0;
                    coin_code_d  = COIN_NONE;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            remain_q     <= '0;
            coin_valid_q <= 1'b0;
            coin_code_q  <= COIN_NONE;
            short_q      <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            coin_valid_q <= coin_valid_d;
            coin_code_q  <= coin_code_d;
            short_q      <= short_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_code  = coin_code_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign short      = short_q;
    assign fault      = fault_q;
    assign remain     = remain_q;

`ifdef VEND_COIN_TALLY_EN
    logic [7:0] tally1_q, tally1_d;
    logic [7:0] tally2_q, tally2_d;
    logic [7:0] tally5_q, tally5_d;

    always_comb begin
        tally1_d = tally1_q;
        tally2_d = tally2_q;
        tally5_d = tally5_q;
        if (state_q == ISSUE && coin_ack) begin
            case (coin_code_q)
                COIN_1:  if (tally1_q != 8'hFF) tally1_d = tally1_q + 8'd1;
                COIN_2:  if (tally2_q != 8'hFF) tally2_d = tally2_q + 8'd1;
                COIN_5:  if (tally5_q != 8'hFF) tally5_d = tally5_q + 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tally1_q <= 8'd0;
            tally2_q <= 8'd0;
            tally5_q <= 8'd0;
        end else begin
            tally1_q <= tally1_d;
            tally2_q <= tally2_d;
            tally5_q <= tally5_d;
        end
    end

    assign tally1 = tally1_q;
    assign tally2 = tally2_q;
    assign tally5 = tally5_q;
`endif

endmodule
